// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a circular byte FIFO feeding a start/data/stop
// serializer that chains queued bytes back to back with no idle gap.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DEPTH        = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         we,
  input  logic [7:0]                   din,
  output logic                         txd,
  output logic                         busy,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX   = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_next;
  logic [BW-1:0]   baud, baud_next;
  logic [2:0]      bit_cnt, bit_next;
  logic [7:0]      shift, shift_next;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count_next;
  logic [7:0]      mem [DEPTH];
  logic            push, pop, txd_next;

  // full is the registered pre-edge value, so a full FIFO drops the byte even
  // if the serializer pops on the same edge.
  assign push = we & ~full;

  always_comb begin
    state_next = state;
    baud_next  = baud + BW'(1);
    bit_next   = bit_cnt;
    shift_next = shift;
    pop        = 1'b0;
    unique case (state)
      IDLE: begin
        baud_next = '0;
        if (!empty) begin
          pop        = 1'b1;
          shift_next = mem[rd_ptr];
          bit_next   = 3'd0;
          state_next = START;
        end
      end
      START: begin
        if (baud == BAUD_MAX) begin
          baud_next  = '0;
          state_next = DATA;
        end
      end
      DATA: begin
        if (baud == BAUD_MAX) begin
          baud_next  = '0;
          shift_next = {1'b0, shift[7:1]};
          bit_next   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        if (baud == BAUD_MAX) begin
          baud_next = '0;
          if (!empty) begin
            pop        = 1'b1;
            shift_next = mem[rd_ptr];
            bit_next   = 3'd0;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // txd is registered from the next state so the line changes on the same
  // edge as the state it reflects.
  always_comb begin
    txd_next = 1'b1;
    unique case (state_next)
      START:   txd_next = 1'b0;
      DATA:    txd_next = shift_next[0];
      default: txd_next = 1'b1;
    endcase
  end

  always_comb begin
    count_next = count;
    unique case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baud     <= '0;
      bit_cnt  <= 3'd0;
      shift    <= 8'h00;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      busy     <= 1'b0;
      txd      <= 1'b1;
      overflow <= 1'b0;
    end else begin
      state    <= state_next;
      baud     <= baud_next;
      bit_cnt  <= bit_next;
      shift    <= shift_next;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count    <= count_next;
      full     <= (count_next == COUNT_FULL);
      empty    <= (count_next == '0);
      busy     <= (state_next != IDLE) | (count_next != '0);
      txd      <= txd_next;
      overflow <= overflow | (we & full);
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a serial monitor decodes frames against a
// scoreboard of accepted bytes while directed sequences check status timing.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset, we;
  logic [7:0]    din;
  logic          txd, busy, full, empty, overflow;
  logic [CW-1:0] count;

  int checks = 0;
  int passed = 0;
  int cyc    = 0;
  int rx_frames = 0;
  bit frame_killed = 1'b0;
  logic [7:0] sb [$];
  int starts [$];

  typedef struct {
    logic          we;
    logic [7:0]    din;
    bit            accept;
    logic [CW-1:0] exp_count;
    logic          exp_full;
    logic          exp_empty;
    logic          exp_ovf;
  } vec_t;

  vec_t vecs [17];

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .we(we), .din(din), .txd(txd), .busy(busy),
    .full(full), .empty(empty), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) frame_killed = 1'b1;
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    else
      passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit accept);
    we  = 1'b1;
    din = b;
    if (accept) sb.push_back(b);
    tick();
    we  = 1'b0;
  endtask

  task automatic apply_stimulus(input vec_t v);
    we  = v.we;
    din = v.din;
    if (v.accept) sb.push_back(v.din);
    tick();
  endtask

  task automatic wait_busy_low(input int limit);
    int n = 0;
    while (busy !== 1'b0 && n < limit) begin
      tick();
      n++;
    end
    check_output("busy_falls_in_time", {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_empty(input int limit);
    int n = 0;
    while (empty !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    check_output("empty_in_time", {31'd0, empty}, 32'd1);
  endtask

  // Serial receiver: finds the start bit, then samples each bit near its middle.
  initial begin
    logic [7:0] data;
    logic       stop_bit;
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      if (txd === 1'b0 && reset === 1'b0) begin
        starts.push_back(cyc);
        frame_killed = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          data[i] = txd;
        end
        repeat (CPB) @(negedge clk);
        stop_bit = txd;
        if (!frame_killed) begin
          rx_frames++;
          check_output("stop_bit", {31'd0, stop_bit}, 32'd1);
          if (sb.size() == 0) begin
            check_output("unexpected_frame", {24'd0, data}, 32'hFFFF_FFFF);
          end else begin
            exp_b = sb.pop_front();
            check_output("rx_byte", {24'd0, data}, {24'd0, exp_b});
          end
        end
      end
    end
  end

  initial begin
    logic [9:0] frame;
    int         n0;
    int         peak;
    int         s0;

    reset = 1'b1;
    we    = 1'b0;
    din   = 8'h00;

    // Reset state
    repeat (2) tick();
    check_output("rst_txd",      {31'd0, txd},      32'd1);
    check_output("rst_busy",     {31'd0, busy},     32'd0);
    check_output("rst_full",     {31'd0, full},     32'd0);
    check_output("rst_empty",    {31'd0, empty},    32'd1);
    check_output("rst_count",    {27'd0, count},    32'd0);
    check_output("rst_overflow", {31'd0, overflow}, 32'd0);
    reset = 1'b0;
    repeat (3) tick();

    // Single byte: exact waveform and busy timing
    push_byte(8'h55, 1'b1);
    check_output("e0_empty", {31'd0, empty}, 32'd0);
    check_output("e0_busy",  {31'd0, busy},  32'd1);
    check_output("e0_count", {27'd0, count}, 32'd1);
    check_output("e0_txd",   {31'd0, txd},   32'd1);
    frame = {1'b1, 8'h55, 1'b0};
    for (int k = 0; k < 10 * CPB; k++) begin
      tick();
      check_output("single_txd", {31'd0, txd}, {31'd0, frame[k / CPB]});
      if (k == 0)          check_output("single_count0", {27'd0, count}, 32'd0);
      if (k == 10*CPB - 1) check_output("single_busy_last", {31'd0, busy}, 32'd1);
    end
    tick();
    check_output("single_busy_fall", {31'd0, busy}, 32'd0);
    check_output("single_idle_txd",  {31'd0, txd},  32'd1);
    repeat (5) tick();

    // Back-to-back frames
    n0 = starts.size();
    push_byte(8'hA3, 1'b1);
    push_byte(8'h0F, 1'b1);
    peak = 1;
    for (int n = 0; n < 200 && busy !== 1'b0; n++) begin
      if (int'(count) > peak) peak = int'(count);
      tick();
    end
    check_output("b2b_peak_count", peak, 32'd1);
    wait_busy_low(10);
    check_output("b2b_frames", starts.size() - n0, 32'd2);
    if (starts.size() >= n0 + 2)
      check_output("b2b_gap", starts[n0+1] - starts[n0], 10 * CPB);
    repeat (5) tick();

    // Overflow while the first frame shifts
    for (int i = 0; i < 17; i++) begin
      vecs[i].we        = 1'b1;
      vecs[i].din       = 8'(i);
      vecs[i].accept    = (i < DEPTH);
      vecs[i].exp_count = CW'((i < DEPTH) ? i + 1 : DEPTH);
      vecs[i].exp_full  = (i >= DEPTH - 1);
      vecs[i].exp_empty = 1'b0;
      vecs[i].exp_ovf   = (i == DEPTH);
    end
    push_byte(8'hEE, 1'b1);
    tick();
    for (int i = 0; i < 17; i++) begin
      apply_stimulus(vecs[i]);
      check_output("ovf_count",    {27'd0, count},    {27'd0, vecs[i].exp_count});
      check_output("ovf_full",     {31'd0, full},     {31'd0, vecs[i].exp_full});
      check_output("ovf_empty",    {31'd0, empty},    {31'd0, vecs[i].exp_empty});
      check_output("ovf_overflow", {31'd0, overflow}, {31'd0, vecs[i].exp_ovf});
    end
    we = 1'b0;
    wait_busy_low(2000);
    check_output("ovf_sticky",   {31'd0, overflow}, 32'd1);
    check_output("ovf_sb_drain", sb.size(), 32'd0);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_output("ovf_cleared", {31'd0, overflow}, 32'd0);
    repeat (3) tick();

    // Pointer wrap: 40 bytes in bursts of 10 with we held high
    n0 = rx_frames;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 10; i++) push_byte(8'((b * 10 + i) * 7 + 3), 1'b1);
      wait_empty(1000);
    end
    wait_busy_low(1000);
    check_output("wrap_frames",   rx_frames - n0,    32'd40);
    check_output("wrap_overflow", {31'd0, overflow}, 32'd0);
    check_output("wrap_sb_drain", sb.size(),         32'd0);
    repeat (3) tick();

    // Reset during data bit 3 with 5 bytes queued
    for (int i = 0; i < 6; i++) push_byte(8'h90 + 8'(i), 1'b1);
    repeat (12) tick();
    check_output("mid_count_before", {27'd0, count}, 32'd5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    check_output("mid_txd",   {31'd0, txd},   32'd1);
    check_output("mid_busy",  {31'd0, busy},  32'd0);
    check_output("mid_empty", {31'd0, empty}, 32'd1);
    check_output("mid_count", {27'd0, count}, 32'd0);
    s0 = starts.size();
    for (int n = 0; n < 60; n++) begin
      tick();
      if (txd !== 1'b1) check_output("mid_quiet_txd", {31'd0, txd}, 32'd1);
    end
    check_output("mid_no_start", starts.size() - s0, 32'd0);

    // Push on the exact edge where STOP ends, with one byte queued
    push_byte(8'h3C, 1'b1);
    tick();
    push_byte(8'hC5, 1'b1);
    repeat (38) tick();
    check_output("coin_count_pre", {27'd0, count}, 32'd1);
    push_byte(8'h7E, 1'b1);
    check_output("coin_count_post", {27'd0, count}, 32'd1);
    check_output("coin_start_txd",  {31'd0, txd},   32'd0);
    wait_busy_low(500);
    check_output("coin_sb_drain", sb.size(), 32'd0);

    repeat (5) tick();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered UART transmitter that sits downstream of the memory-mapped I/O register block. It accepts byte writes from the UART data register on a single-cycle strobe and queues them in an internal FIFO. It serializes them onto `txd` as 8N1 frames (LSB first) with no idle gap between queued bytes. Status outputs feed back into the register block's UART status register.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per serial bit (100 MHz / 115200). Must be ≥ 2.
- `DEPTH`, default 16: FIFO depth in bytes. Power of two, ≥ 2.
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `we`  in  1  push strobe; `din` is captured on the rising edge where `we`=1.
- `din`  in  8  byte to transmit.
- `txd`  out  1  serial output; idles high.
- `busy`  out  1  high while a frame is in progress or the FIFO is non-empty.
- `full`  out  1  FIFO holds `DEPTH` bytes.
- `empty`  out  1  FIFO holds 0 bytes.
- `count`  out  $clog2(DEPTH+1)  number of bytes queued, excluding the byte being shifted.
- `overflow`  out  1  sticky flag; set when a push is attempted while `full`. Cleared only by `reset`.

## Operation
- FIFO:
  - Circular buffer with `log2(DEPTH)`-bit read/write pointers that wrap modulo `DEPTH`.
  - `full` and `empty` are registered and derived from `count`.
- Push: on an edge with `we`=1 and `full`=0, write `din` at the write pointer and advance the pointer.
- Push with `full`=1:
  - The byte is dropped and `overflow` is set.
  - The push is dropped even if a pop occurs on the same edge; `full` is evaluated pre-edge.
- Pop: performed by the serializer only, when it loads a byte. A pop and a push on the same edge leave `count` unchanged.
- Serializer FSM states: IDLE, START, DATA, STOP.
  - IDLE: `txd`=1. If `empty`=0, pop into the shift register, clear the bit counter, go to START.
  - START: `txd`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: `txd`=shift[0] for `CLKS_PER_BIT` cycles per bit, shifting right after each bit. After 8 bits, go to STOP.
  - STOP: `txd`=1 for `CLKS_PER_BIT` cycles.
    - On the final cycle, if `empty`=0, pop and go directly to START (back-to-back frames).
    - Otherwise go to IDLE.
- Counters:
  - Baud counter is `$clog2(CLKS_PER_BIT)` bits, counts 0..`CLKS_PER_BIT`-1, and is reset on every state change.
  - Bit counter is 3 bits.
- `busy` = (state ≠ IDLE) | ~`empty`, registered.
- `txd` is driven from a flop, so it is glitch-free.

## Timing
- Reset values:
  - `txd`=1, `busy`=0, `full`=0, `empty`=1, `count`=0, `overflow`=0.
  - State IDLE, both pointers 0.
- Reset asserted mid-frame: on the next edge `txd`=1 and the FIFO is emptied. The partial frame is abandoned; there is no completion of the stop bit.
- Latency from an accepted push into an empty, idle block:
  - Write edge E0: `empty` falls after E0.
  - Edge E1: pop, START; `txd` low from E1.
  - `busy` is high from E0.
- Frame length is exactly 10×`CLKS_PER_BIT` cycles.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle.
- `busy` falls on the edge where the STOP→IDLE transition occurs with the FIFO empty.
- `count`, `full` and `empty` update on the edge after the push/pop edge.
  - `full` is asserted once `DEPTH` bytes are queued.
  - While frame N is shifting, the FIFO can accept up to `DEPTH` further bytes before `full`.
- `we` held high for multiple cycles pushes one byte per cycle.

## Test plan
- Single byte, `CLKS_PER_BIT`=4: push 0x55 into an idle block.
  - `txd` reads 0,1,0,1,0,1,0,1,0,1 with each level held 4 cycles, starting 1 cycle after the push.
  - `busy` falls 40 cycles after the start bit begins.
- Back-to-back: push 0xA3 then 0x0F on consecutive cycles.
  - Two contiguous 40-cycle frames, LSB first, with no high gap between the stop bit and the next start bit.
  - `count` peaks at 1.
- Overflow, `DEPTH`=16: while frame 1 shifts, push 17 further bytes (0x00..0x10).
  - `full`=1 after the 16th.
  - The 17th (0x10) is dropped and `overflow`=1 stays set.
  - The output stream is bytes 0x00..0x0F after the first byte.
- Pointer wrap: push 40 bytes in bursts of 10, waiting for `empty` between bursts.
  - All 40 bytes are transmitted in order.
  - `overflow` stays 0.
- Reset mid-frame: assert `reset` for 1 cycle during DATA bit 3 with 5 bytes queued.
  - `txd`=1 on the next edge; `busy`=0, `empty`=1, `count`=0.
  - No further start bit occurs until a new push.
- Push coinciding with pop: with `count`=1, push on the exact edge where STOP ends.
  - `count` remains 1.
  - Both bytes are transmitted in order.
